// File: rtl/counter_4b_ctrl.sv
// Command sequencer for one 4-bit counter: preloads it and runs it until the requested
// number of rco pulses. It then reports done, or reports err if the rco watchdog expires.
module counter_4b_ctrl #(
  parameter int WRAP_W  = 4,
  parameter int TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [3:0]        cmd_D,
  input  logic [WRAP_W-1:0] cmd_wraps,
  input  logic              pause,
  input  logic              abort,
  output logic              ctr_enable,
  output logic [1:0]        ctr_mode,
  output logic [3:0]        ctr_D,
  output logic              ctr_load,
  input  logic              ctr_rco,
  input  logic [3:0]        ctr_Q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [3:0]        final_Q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [5:0]        TIMEOUT_V = 6'(TIMEOUT);
  localparam logic [WRAP_W-1:0] WRAP_ONE  = WRAP_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        mode_q;
  logic [3:0]        d_q;
  logic [WRAP_W-1:0] wraps_q;
  logic [WRAP_W-1:0] wrap_cnt_q;
  logic [5:0]        wdog_q;
  logic              err_q;
  logic [3:0]        final_q_r;

  logic              accept;
  logic              cmd_zero;
  logic              run_en;
  logic              rco_hit;
  logic              last_hit;
  logic              timeout_hit;
  logic [WRAP_W-1:0] wrap_inc;
  logic [5:0]        wdog_inc;

  // Abort masks both rco counting and the watchdog, so it always wins in RUN.
  always_comb begin
    accept      = (state == S_IDLE) && cmd_valid;
    cmd_zero    = (cmd_wraps == '0);
    run_en      = (state == S_RUN) && !pause;
    wrap_inc    = wrap_cnt_q + WRAP_ONE;
    wdog_inc    = wdog_q + 6'd1;
    rco_hit     = run_en && ctr_rco && !abort;
    last_hit    = rco_hit && (wrap_inc == wraps_q);
    timeout_hit = run_en && !ctr_rco && !abort && (wdog_inc == TIMEOUT_V);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = cmd_zero ? S_ERR : S_LOAD;
        end
      end
      S_LOAD: state_nxt = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (last_hit) begin
          state_nxt = S_DONE;
        end else if (timeout_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // err is set on entry to ERR so it is already visible during the ERR cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q     <= '0;
      d_q        <= '0;
      wraps_q    <= '0;
      wrap_cnt_q <= '0;
      wdog_q     <= '0;
      err_q      <= 1'b0;
      final_q_r  <= '0;
    end else begin
      if (accept) begin
        mode_q     <= cmd_mode;
        d_q        <= cmd_D;
        wraps_q    <= cmd_wraps;
        wrap_cnt_q <= '0;
        wdog_q     <= '0;
        err_q      <= cmd_zero;
      end else if (rco_hit) begin
        wrap_cnt_q <= wrap_inc;
        wdog_q     <= '0;
        if (last_hit) begin
          final_q_r <= ctr_Q;
        end
      end else if (run_en && !abort) begin
        wdog_q <= wdog_inc;
        if (timeout_hit) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    ctr_load   = 1'b0;
    ctr_enable = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_LOAD: begin
        ctr_load   = 1'b1;
        ctr_enable = 1'b1;
      end
      S_RUN:   ctr_enable = !pause;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign ctr_mode = mode_q;
  assign ctr_D    = d_q;
  assign err      = err_q;
  assign wrap_cnt = wrap_cnt_q;
  assign final_Q  = final_q_r;

endmodule

// File: doc/counter_4b_ctrl.md
Name: counter_4b_ctrl

Overview:
- Command sequencer for the 4-bit counter (enable/mode/D/load in, Q/rco out).
- Accepts one command at a time (start value, count mode, number of rco events to wait for), then:
  - preloads the counter;
  - runs it until the requested number of rco pulses has occurred;
  - reports completion or a timeout error.
- Sits between a tester or host and one counter_4b instance (behavioural or synthesized).

Parameters:
- WRAP_W, 4, width of the requested rco-event count (1..2^WRAP_W-1 events).
- TIMEOUT, 40, maximum RUN cycles allowed between consecutive rco pulses before error; 6-bit watchdog.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command (high only in IDLE).
- cmd_mode  in  2  counter mode to run with (00/01/10/11, passed through unmodified).
- cmd_D  in  4  start value for the counter.
- cmd_wraps  in  WRAP_W  number of rco pulses to wait for; 0 is illegal.
- pause  in  1  holds counter enable low while in RUN.
- abort  in  1  terminate current command.
- ctr_enable  out  1  to counter enable.
- ctr_mode  out  2  to counter mode.
- ctr_D  out  4  to counter D.
- ctr_load  out  1  to counter load.
- ctr_rco  in  1  from counter rco.
- ctr_Q  in  4  from counter Q; captured at completion.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag; cleared by next accepted command.
- wrap_cnt  out  WRAP_W  rco pulses seen in current command.
- final_Q  out  4  ctr_Q sampled on the cycle the last rco is seen.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All outputs 0, except cmd_ready=1.
  - Registered mode, D and wrap count cleared.
  - Reset asserted mid-command abandons the command with no done pulse.
- States: IDLE, LOAD, RUN, DONE, ERR. All outputs are registered or decoded from state.
- IDLE:
  - cmd_ready=1, ctr_enable=0, ctr_load=0.
  - Handshake: a command is accepted when cmd_valid & cmd_ready at a rising edge.
  - On acceptance: latch cmd_mode, cmd_D, cmd_wraps; clear wrap_cnt, err, watchdog.
  - If cmd_wraps==0: go to ERR. Otherwise go to LOAD.
- LOAD (exactly 1 cycle):
  - ctr_load=1, ctr_enable=1, ctr_D=latched D, ctr_mode=latched mode.
  - Next state RUN.
- RUN:
  - ctr_load=0, ctr_mode=latched mode, ctr_enable = !pause.
  - Each cycle with ctr_rco=1 and ctr_enable=1 increments wrap_cnt; rco while paused is ignored.
  - When the increment makes wrap_cnt equal the latched count: sample ctr_Q into final_Q, then go to DONE.
  - Watchdog:
    - Increments on each enabled cycle without rco; cleared on rco.
    - Frozen while paused.
    - Reaching TIMEOUT goes to ERR.
- DONE (1 cycle): done=1, ctr_enable=0; next state IDLE.
- ERR (1 cycle): err set (sticky), ctr_enable=0, no done pulse; next state IDLE.
- abort:
  - Sampled in LOAD or RUN; moves to IDLE on the next edge.
  - ctr_enable drops that edge; no done pulse, no err.
  - Has priority over rco completion and timeout in the same cycle.
  - Ignored in IDLE, DONE and ERR.
- Latency: command acceptance to first enabled count = 2 edges (accept -> LOAD -> RUN).
- cmd inputs are don't-care outside the acceptance cycle; changes mid-command have no effect.
- wrap_cnt and final_Q hold their values in IDLE until the next acceptance.
- wrap_cnt never exceeds the latched count (no wrap-around of wrap_cnt).

Test Plan:
- Reset at any point -> outputs 0, cmd_ready=1; drive reset low mid-RUN -> ctr_enable 0 immediately (async), no done.
- cmd_mode=00, cmd_D=4'hC, cmd_wraps=2; tester counter rco at Q=F:
  - ctr_load high exactly 1 cycle with ctr_D=C.
  - After the 2nd rco: done pulse 1 cycle, wrap_cnt=2, final_Q=F, then cmd_ready=1.
- Same command with pause held 3 cycles in RUN:
  - ctr_enable=0 for those 3 cycles.
  - rco forced during pause is not counted.
  - done arrives 3 cycles later than the unpaused run.
- cmd_wraps=0 -> ERR next cycle, err=1, no ctr_load, no done; next valid command clears err.
- Hold ctr_rco=0 in RUN -> err=1 after 40 enabled cycles, ctr_enable=0, wrap_cnt=0.
- abort asserted on the same cycle as the final rco -> IDLE, no done, no err, final_Q unchanged; cmd_valid during DONE/ERR not accepted (cmd_ready=0).
